// File: rtl/filter_weight_loader_if.sv
// Address-stream, weight-memory and row-output signals of the filter weight loader.
// The loader connects through the slave modport; its environment uses master.
interface filter_weight_loader_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0]   addr_in;
   logic                    addr_valid;
   logic                    row_sync;
   logic                    flush;
   logic                    mem_rd_en;
   logic [ADDR_WIDTH-1:0]   mem_rd_addr;
   logic [DATA_WIDTH-1:0]   mem_rd_data;
   logic [3*DATA_WIDTH-1:0] row_data;
   logic                    row_valid;
   logic                    row_ready;
   logic [15:0]             row_count;
   logic                    err_overflow;
   logic                    err_sync;

   modport slave (
      input  addr_in, addr_valid, row_sync, flush, mem_rd_data, row_ready,
      output mem_rd_en, mem_rd_addr, row_data, row_valid, row_count,
             err_overflow, err_sync
   );

   modport master (
      output addr_in, addr_valid, row_sync, flush, mem_rd_data, row_ready,
      input  mem_rd_en, mem_rd_addr, row_data, row_valid, row_count,
             err_overflow, err_sync
   );
endinterface

// File: rtl/filter_weight_loader.sv
// Issues weight-memory reads per filter address, packs three returned weights
// per kernel row and buffers rows in a small FIFO drained by valid/ready.
module filter_weight_loader #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_LATENCY = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   filter_weight_loader_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int RW = 3*DATA_WIDTH;
   localparam logic [PW:0] PTR_ONE = 1;

   // request stage
   logic [1:0]            req_tap, req_pos, tag_q;
   logic                  rd_en_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic                  sync_err, err_sync_q;

   // row_sync pins the request to tap 1, resynchronising the packer
   always_comb begin
      sync_err = bus.addr_valid && bus.row_sync && (req_tap != 2'd1);
      req_pos  = sync_err ? 2'd1 : req_tap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         req_tap    <= 2'd0;
         tag_q      <= 2'd0;
         err_sync_q <= 1'b0;
      end else if (bus.flush) begin
         rd_en_q <= 1'b0;
         req_tap <= 2'd0;
      end else begin
         rd_en_q <= bus.addr_valid;
         if (bus.addr_valid) begin
            rd_addr_q <= bus.addr_in;
            tag_q     <= req_pos;
            req_tap   <= (req_pos == 2'd2) ? 2'd0 : req_pos + 2'd1;
         end
         if (sync_err) err_sync_q <= 1'b1;
      end
   end

   // return tracking: valid and tap tag follow each read through the memory
   logic [MEM_LATENCY-1:0]      vld_pipe;
   logic [MEM_LATENCY-1:0][1:0] tag_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else if (bus.flush) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= rd_en_q;
         tag_pipe[0] <= tag_q;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   // tap packer
   logic                  cap, push;
   logic [1:0]            cap_tap;
   logic [DATA_WIDTH-1:0] w0, w1;
   logic [RW-1:0]         push_row;

   always_comb begin
      cap      = vld_pipe[MEM_LATENCY-1] && !bus.flush;
      cap_tap  = tag_pipe[MEM_LATENCY-1];
      push     = cap && (cap_tap == 2'd2);
      push_row = {bus.mem_rd_data, w1, w0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w0 <= '0;
         w1 <= '0;
      end else if (cap) begin
         if (cap_tap == 2'd0) w0 <= bus.mem_rd_data;
         if (cap_tap == 2'd1) w1 <= bus.mem_rd_data;
      end
   end

   // row FIFO; pointers carry a wrap bit to tell full from empty
   logic [RW-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW:0]   wr_ptr, rd_ptr;
   logic [15:0]   count_q;
   logic          empty, full, pop, push_ok, err_ovf_q;

   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
      pop     = !empty && bus.row_ready && !bus.flush;
      push_ok = push && (!full || pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         err_ovf_q <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr  <= wr_ptr + PTR_ONE;
            count_q <= count_q + 16'd1;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !push_ok) err_ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr[PW-1:0]] <= push_row;
   end

   assign bus.mem_rd_en    = rd_en_q;
   assign bus.mem_rd_addr  = rd_addr_q;
   assign bus.row_valid    = !empty;
   assign bus.row_data     = empty ? '0 : fifo_mem[rd_ptr[PW-1:0]];
   assign bus.row_count    = count_q;
   assign bus.err_overflow = err_ovf_q;
   assign bus.err_sync     = err_sync_q;
endmodule

// File: tb/tb_filter_weight_loader.sv
// Directed bench: two loaders (memory latency 1 and 3) share one stimulus stream.
module tb_filter_weight_loader;
   logic        clk, rst_n;
   logic [31:0] addr_in;
   logic        addr_valid, row_sync, flush, row_ready;
   int          nvec = 0, nerr = 0;

   filter_weight_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) b1 ();
   filter_weight_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) b3 ();

   filter_weight_loader #(.MEM_LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   filter_weight_loader #(.MEM_LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

   assign b1.addr_in = addr_in;     assign b3.addr_in = addr_in;
   assign b1.addr_valid = addr_valid; assign b3.addr_valid = addr_valid;
   assign b1.row_sync = row_sync;   assign b3.row_sync = row_sync;
   assign b1.flush = flush;         assign b3.flush = flush;
   assign b1.row_ready = row_ready; assign b3.row_ready = row_ready;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // weight stored at 0x10N is 0x11*(N+1)
   function automatic logic [7:0] m(input logic [31:0] a);
      logic [7:0] n;
      n = {4'h0, a[3:0]} + 8'd1;
      return n * 8'h11;
   endfunction

   function automatic logic [23:0] row(input logic [31:0] base);
      return {m(base + 2), m(base + 1), m(base)};
   endfunction

   // weight memories with read latency 1 and 3
   logic [7:0] p3 [3];
   always @(posedge clk) b1.mem_rd_data <= m(b1.mem_rd_addr);
   always @(posedge clk) begin
      p3[0] <= m(b3.mem_rd_addr);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign b3.mem_rd_data = p3[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rden1"}, b1.mem_rd_en, 0);
      chk({tag, "_rdaddr1"}, b1.mem_rd_addr, 0);
      chk({tag, "_valid1"}, b1.row_valid, 0);
      chk({tag, "_data1"}, b1.row_data, 0);
      chk({tag, "_count1"}, b1.row_count, 0);
      chk({tag, "_ovf1"}, b1.err_overflow, 0);
      chk({tag, "_sync1"}, b1.err_sync, 0);
      chk({tag, "_rdaddr3"}, b3.mem_rd_addr, 0);
      chk({tag, "_count3"}, b3.row_count, 0);
      chk({tag, "_ovf3"}, b3.err_overflow, 0);
   endtask

   initial begin
      rst_n = 1'b0; addr_in = '0; addr_valid = 1'b0; row_sync = 1'b0;
      flush = 1'b0; row_ready = 1'b0;
      step(); step();
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      step();

      // single row, addresses three cycles apart
      row_ready = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         addr_valid = (c == 0 || c == 3 || c == 6);
         addr_in    = 32'h100 + c / 3;
         row_sync   = (c == 3);
         @(negedge clk);
         if (c == 1) begin
            chk("single_rden", b1.mem_rd_en, 1);
            chk("single_rdaddr", b1.mem_rd_addr, 32'h100);
         end
         if (c == 2) begin
            chk("single_rden_off", b1.mem_rd_en, 0);
            chk("single_rdaddr_hold", b1.mem_rd_addr, 32'h100);
         end
         if (c == 8) chk("single_early", b1.row_valid, 0);
         if (c == 9) begin
            chk("single_valid", b1.row_valid, 1);
            chk("single_data", b1.row_data, 24'h332211);
            chk("single_count", b1.row_count, 1);
            chk("single_sync", b1.err_sync, 0);
            chk("single_ovf", b1.err_overflow, 0);
         end
         step();
      end

      // back-to-back addresses, both latencies
      do_flush();
      for (int c = 0; c <= 20; c++) begin
         addr_valid = (c < 12);
         addr_in    = 32'h100 + c;
         row_sync   = (c < 12) && (c % 3 == 1);
         @(negedge clk);
         if (c >= 5 && c <= 14 && (c - 5) % 3 == 0) begin
            chk("b2b_valid1", b1.row_valid, 1);
            chk("b2b_data1", b1.row_data, row(32'h100 + c - 5));
         end
         if (c >= 7 && c <= 16 && (c - 7) % 3 == 0) begin
            chk("b2b_valid3", b3.row_valid, 1);
            chk("b2b_data3", b3.row_data, row(32'h100 + c - 7));
         end
         step();
      end
      chk("b2b_count1", b1.row_count, 4);
      chk("b2b_count3", b3.row_count, 4);

      // full FIFO with a pop in the same cycle as the fifth push
      row_ready = 1'b0;
      do_flush();
      for (int c = 0; c <= 18; c++) begin
         addr_valid = (c < 15);
         addr_in    = 32'h100 + c;
         row_sync   = (c < 15) && (c % 3 == 1);
         row_ready  = (c == 16);
         @(negedge clk);
         if (c == 15) chk("full_count4", b1.row_count, 4);
         if (c == 16) chk("full_head", b1.row_data, row(32'h100));
         if (c == 17) begin
            chk("full_head2", b1.row_data, row(32'h103));
            chk("full_count5", b1.row_count, 5);
            chk("full_ovf", b1.err_overflow, 0);
         end
         step();
      end

      // row_sync on the first address of a row
      do_flush();
      row_ready = 1'b1;
      for (int c = 0; c <= 9; c++) begin
         addr_valid = (c < 5);
         addr_in    = 32'h104 + c;
         row_sync   = (c == 0 || c == 3);
         @(negedge clk);
         if (c == 0) chk("sync_pre", b1.err_sync, 0);
         if (c == 1) chk("sync_set", b1.err_sync, 1);
         if (c == 4) begin
            chk("sync_short_valid", b1.row_valid, 1);
            chk("sync_short_data", b1.row_data[23:8], 16'h6655);
         end
         if (c == 7) begin
            chk("sync_realign_valid", b1.row_valid, 1);
            chk("sync_realign_data", b1.row_data, 24'h998877);
         end
         if (c == 8) begin
            chk("sync_count", b1.row_count, 2);
            chk("sync_sticky", b1.err_sync, 1);
         end
         step();
      end

      // backpressure: five rows into a four-deep FIFO
      row_ready = 1'b0;
      do_flush();
      for (int c = 0; c <= 17; c++) begin
         addr_valid = (c < 15);
         addr_in    = 32'h100 + c;
         row_sync   = (c < 15) && (c % 3 == 1);
         @(negedge clk);
         if (c == 17) begin
            chk("ovf_count", b1.row_count, 4);
            chk("ovf_err", b1.err_overflow, 1);
            chk("ovf_valid", b1.row_valid, 1);
         end
         step();
      end
      for (int k = 0; k <= 4; k++) begin
         row_ready = (k < 4);
         @(negedge clk);
         if (k < 4) chk("ovf_drain", b1.row_data, row(32'h100 + 3 * k));
         else chk("ovf_empty", b1.row_valid, 0);
         step();
      end

      // flush after two addresses of a row
      row_ready = 1'b1;
      for (int c = 0; c <= 12; c++) begin
         addr_valid = (c < 2) || (c >= 6 && c < 9);
         addr_in    = (c < 2) ? 32'h100 + c : 32'h103 + (c - 6);
         row_sync   = (c == 1 || c == 7);
         flush      = (c == 2);
         @(negedge clk);
         if (c == 3) begin
            chk("flush_count", b1.row_count, 0);
            chk("flush_valid", b1.row_valid, 0);
         end
         if (c == 5) chk("flush_late", b1.row_valid, 0);
         if (c == 11) begin
            chk("flush_row_valid", b1.row_valid, 1);
            chk("flush_row_data", b1.row_data, 24'h665544);
            chk("flush_row_count", b1.row_count, 1);
         end
         if (c == 12) chk("flush_ovf_sticky", b1.err_overflow, 1);
         step();
      end

      // reset mid-row, then a fresh row
      row_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         addr_valid = 1'b1;
         addr_in    = 32'h100 + c;
         row_sync   = (c == 1);
         step();
      end
      addr_valid = 1'b0; row_sync = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk_zero("midreset");
      step();
      rst_n = 1'b1;
      step();
      for (int c = 0; c <= 6; c++) begin
         addr_valid = (c < 3);
         addr_in    = 32'h100 + c;
         row_sync   = (c == 1);
         @(negedge clk);
         if (c == 5) begin
            chk("post_valid", b1.row_valid, 1);
            chk("post_data", b1.row_data, 24'h332211);
            chk("post_count", b1.row_count, 1);
            chk("post_sync", b1.err_sync, 0);
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/filter_weight_loader.md
# filter_weight_loader

Sits directly downstream of the filter address generator and consumes its address stream, one read address per valid pulse. For each address it issues a read to the synchronous filter-weight memory. It packs every three returned weights (one kernel row) into a single row word and buffers the rows in a small FIFO. The convolution datapath drains rows from the FIFO through a valid/ready handshake.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of filter addresses and memory address.
- DATA_WIDTH, 8, width of one weight.
- MEM_LATENCY, 1, fixed read latency of the weight memory in cycles (legal 1..4).
- FIFO_DEPTH, 4, row FIFO depth (power of two, >= 2).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr_in  in  ADDR_WIDTH  filter address from generator.
- addr_valid  in  1  addr_in valid this cycle (no backpressure upstream).
- row_sync  in  1  generator's row marker; asserted with the 2nd address of each row.
- flush  in  1  synchronous clear of partial row, in-flight reads and FIFO.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  memory read address.
- mem_rd_data  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_rd_en.
- row_data  out  3*DATA_WIDTH  packed row {w2,w1,w0}; w0 = first address of the row, in the LSBs.
- row_valid  out  1  FIFO non-empty.
- row_ready  in  1  consumer accepts row_data when row_valid && row_ready.
- row_count  out  16  rows pushed since reset/flush (wraps at 65535 -> 0).
- err_overflow  out  1  sticky: a row was dropped because the FIFO was full.
- err_sync  out  1  sticky: row_sync arrived when the tap index was not 1.

## Operation
- Request stage (registered): on addr_valid, next cycle mem_rd_en=1 and mem_rd_addr=addr_in; otherwise mem_rd_en=0 and mem_rd_addr holds its last value.
- Return tracking: a MEM_LATENCY-deep valid shift register follows mem_rd_en. Its output marks the cycles in which mem_rd_data is captured.
- Tap packer: a 2-bit tap index counts 0,1,2.
  - Capture at tap 0: store w0, index -> 1.
  - Capture at tap 1: store w1, index -> 2.
  - Capture at tap 2: push {data,w1,w0} into the FIFO, increment row_count, index -> 0.
- Sync check: the tap index is sampled at the request stage, i.e. the request's tap position. When row_sync=1 with addr_valid and that position is not 1, set err_sync and force the position to 1, so the address is tagged as tap 1.
- FIFO, push rules:
  - A push when the FIFO is not full succeeds.
  - A push when the FIFO is full succeeds only if a pop occurs in the same cycle.
  - Otherwise the row is dropped, err_overflow=1, and row_count does not increment.
- FIFO, pop rule: pop on row_valid && row_ready. row_data always shows the head entry.
- Empty pop: row_ready with row_valid=0 has no effect.
- flush:
  - Clears the tap index, the return shift register, the FIFO and row_count.
  - Reads already issued are discarded (returning data is ignored).
  - Sticky errors are NOT cleared; only rst_n clears them.
- Reset (rst_n low, any time including mid-row):
  - mem_rd_en=0, mem_rd_addr=0, row_valid=0, row_data=0, row_count=0, err_overflow=0, err_sync=0.
  - Tap index=0, FIFO empty.

## Timing
- addr_valid at cycle t -> mem_rd_en at t+1 -> data captured at t+1+MEM_LATENCY.
- Third address of a row at t -> row_valid at t+2+MEM_LATENCY when the FIFO is empty.
- Throughput: one address per cycle sustained; the 3-cycle upstream spacing is not required.
- Pop at cycle t: the next head appears on row_data at t+1. row_valid deasserts at t+1 if the FIFO is then empty.
- Simultaneous push and pop on an empty FIFO: the pop is ignored (row_valid=0) and the push succeeds.
- flush has priority over push and pop in the same cycle.

## Test plan
- Single row: addresses 0x100,0x101,0x102 spaced 3 cycles, row_sync on the 2nd; memory returns 0x11,0x22,0x33 -> row_data=0x332211, row_valid at third-address cycle+3 (MEM_LATENCY=1), row_count=1, no errors.
- Back-to-back: 12 consecutive addresses, row_ready=1 -> 4 rows in order, row_count=4; repeat with MEM_LATENCY=3 for identical data with each row 2 cycles later.
- Backpressure: row_ready=0, 5 rows -> 4 rows buffered, 5th dropped, err_overflow=1, row_count=4. Then assert row_ready for 4 cycles -> rows 1-4 pop in order and row_valid=0 afterwards.
- Full with simultaneous pop: FIFO full, row_ready=1 in the push cycle -> no drop, err_overflow stays 0.
- Sync error: row_sync on the 1st address of a row -> err_sync=1. The next two returns complete that row, giving 2 weights per row, and the following rows re-align.
- Reset and flush mid-row: after 2 of 3 addresses, assert flush -> FIFO empty, row_count=0, the late return is ignored. Next full row packs correctly; repeat using rst_n low -> all outputs return to 0.
